pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Fetch-stage sequencing controller that drives the program counter's `stall`, `jump_cs` and `Next_pc` inputs. It arbitrates between three redirect sources: trap, taken branch from EX, and jump from ID. It also merges load-use hazard stalls with instruction-memory wait states, and holds a redirect that arrives while memory is busy. It generates the pipeline flush strobes that go with each redirect and performs the post-reset load of the boot vector.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, address loaded into the PC in the first cycle after reset release
- TRAP_VEC, 32'h0000_0080, fixed trap handler address

Ports:
- clk  in  1  single rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- imem_ready  in  1  instruction memory accepts/returns a fetch this cycle
- hazard_stall  in  1  load-use stall request from decode
- trap  in  1  exception request from EX/MEM
- br_taken  in  1  resolved taken branch in EX
- br_target  in  32  branch target
- jump  in  1  unconditional jump decoded in ID
- jump_target  in  32  jump target
- stall  out  1  to PC `stall`
- jump_cs  out  1  to PC `jump_cs`
- next_pc  out  32  to PC `Next_pc`
- flush_if  out  1  kill the IF/ID register contents
- flush_id  out  1  kill the ID/EX register contents
- flush_ex  out  1  kill the EX/MEM register contents
- redirect_cnt  out  16  count of issued redirects, wraps 16'hFFFF→0

## Operation
- Registered state: `st` ∈ {BOOT, RUN, PEND}, `pend_pc[31:0]`, `pend_src[1:0]` (0 = jump, 1 = branch, 2 = trap), `redirect_cnt`.
- All other outputs are combinational from the registered state and the current inputs. The PC samples them at the next posedge.
- Invariant: `stall` and `jump_cs` are never both 1, because the PC gives `stall` priority.
- Every target has bits [1:0] forced to 00 before use.
- Reset asserted, at any time, mid-operation included:
  - `st` = BOOT, `pend_pc` = 0, `pend_src` = 0, `redirect_cnt` = 0.
  - Outputs held at: stall=1, jump_cs=0, next_pc=RESET_VEC, flush_if/id/ex=1.
- BOOT, first cycle after release:
  - Outputs: jump_cs=1, next_pc=RESET_VEC, stall=0, flush_if=flush_id=flush_ex=1.
  - Go to RUN. Does not increment `redirect_cnt`. All request inputs are ignored.
- RUN: the selected request is trap > br_taken > jump; the older instruction wins.
  - Request present and imem_ready=1: issue the redirect. jump_cs=1, next_pc = target, stall=0, `redirect_cnt`+1. hazard_stall is ignored.
  - Request present and imem_ready=0: latch the target and source into `pend_pc`/`pend_src`. Assert stall=1 and go to PEND. No flush this cycle.
  - No request: stall = hazard_stall | ~imem_ready, jump_cs=0, next_pc = 0, flushes 0.
- PEND:
  - imem_ready=0: stall=1. A new request with a strictly higher source rank than `pend_src` overwrites `pend_pc`/`pend_src`. Equal or lower rank is ignored.
  - imem_ready=1: issue the redirect from `pend_pc`, `redirect_cnt`+1, go to RUN. If a strictly higher-rank request arrives in this same cycle, issue it instead.
- Flush strobes are asserted only in the cycle jump_cs=1:
  - jump: flush_if
  - branch: flush_if, flush_id
  - trap: flush_if, flush_id, flush_ex

## Timing
- Redirect latency: a request in cycle N with imem_ready=1 means pc_curr = target after the posedge ending cycle N.
- A deferred redirect issues in the first cycle where imem_ready=1. Latency = wait cycles + 1.
- Stall latency: 0. The PC holds on the same edge the stall is asserted.
- The reset release edge is followed by exactly one BOOT cycle.
- `redirect_cnt` updates on the edge ending the issue cycle.

## Test plan
- Reset, then release with imem_ready=1 → cycle 1: jump_cs=1, next_pc=0x0, all flushes=1. Cycle 2: RUN, stall=0, jump_cs=0.
- trap, br_taken (0x100) and jump (0x200) in the same cycle, imem_ready=1 → next_pc=0x80, flush_if/id/ex=1, redirect_cnt=1.
- jump to 0x403 with imem_ready=0 for 3 cycles → stall=1 for 3 cycles. Cycle 4: jump_cs=1, next_pc=0x400, only flush_if.
- In PEND holding a jump (0x200), br_taken to 0x300 arrives → issued next_pc=0x300 with flush_if+flush_id. A later jump arriving while PEND holds a branch is ignored.
- hazard_stall=1 with br_taken (0x40) in the same cycle → stall=0, jump_cs=1, next_pc=0x40. With hazard_stall alone → stall=1, jump_cs=0.
- rst_n dropped while in PEND → outputs take their reset values immediately, without waiting for a clock edge. After release the BOOT sequence runs and the pending target is lost. Also run 65536 redirects → redirect_cnt wraps to 0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage sequencer for the program counter.
// Arbitrates trap / taken branch / jump redirects, merges hazard and
// instruction-memory stalls, parks a redirect while memory is busy,
// raises the matching pipeline flushes and loads the boot vector.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        hazard_stall,
  input  logic        trap,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        stall,
  output logic        jump_cs,
  output logic [31:0] next_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} st_t;

  // Source rank: a higher value is an older instruction and wins.
  localparam logic [1:0]  SRC_JUMP  = 2'd0;
  localparam logic [1:0]  SRC_BR    = 2'd1;
  localparam logic [1:0]  SRC_TRAP  = 2'd2;
  localparam logic [31:0] ALIGN_MSK = 32'hFFFF_FFFC;

  st_t         st_q, st_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [1:0]  pend_src_q, pend_src_d;
  logic [15:0] cnt_q, cnt_d;

  logic        req_vld;
  logic [1:0]  req_src;
  logic [31:0] req_tgt;
  logic        req_wins;
  logic        issue;
  logic [1:0]  issue_src;
  logic [31:0] issue_tgt;

  assign redirect_cnt = cnt_q;

  // Pick the highest-ranked live request and its word-aligned target.
  always_comb begin
    req_vld = trap | br_taken | jump;
    req_src = SRC_JUMP;
    req_tgt = jump_target & ALIGN_MSK;
    if (trap) begin
      req_src = SRC_TRAP;
      req_tgt = TRAP_VEC & ALIGN_MSK;
    end else if (br_taken) begin
      req_src = SRC_BR;
      req_tgt = br_target & ALIGN_MSK;
    end
    // Only a strictly older source may displace a parked redirect.
    req_wins = req_vld && (req_src > pend_src_q);
  end

  // Sequencing: next state, PC controls and flushes for this cycle.
  always_comb begin
    st_d       = st_q;
    pend_pc_d  = pend_pc_q;
    pend_src_d = pend_src_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    jump_cs    = 1'b0;
    next_pc    = 32'h0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    issue      = 1'b0;
    issue_src  = SRC_JUMP;
    issue_tgt  = 32'h0;

    case (st_q)
      BOOT: begin
        // Boot-vector load; requests are ignored and not counted.
        jump_cs  = 1'b1;
        next_pc  = RESET_VEC & ALIGN_MSK;
        flush_if = 1'b1;
        flush_id = 1'b1;
        flush_ex = 1'b1;
        st_d     = RUN;
      end
      RUN: begin
        if (req_vld) begin
          if (imem_ready) begin
            issue     = 1'b1;
            issue_src = req_src;
            issue_tgt = req_tgt;
          end else begin
            // Memory busy: park the redirect and hold the PC.
            pend_pc_d  = req_tgt;
            pend_src_d = req_src;
            stall      = 1'b1;
            st_d       = PEND;
          end
        end else begin
          stall = hazard_stall | ~imem_ready;
        end
      end
      PEND: begin
        if (!imem_ready) begin
          stall = 1'b1;
          if (req_wins) begin
            pend_pc_d  = req_tgt;
            pend_src_d = req_src;
          end
        end else begin
          issue = 1'b1;
          st_d  = RUN;
          if (req_wins) begin
            issue_src = req_src;
            issue_tgt = req_tgt;
          end else begin
            issue_src = pend_src_q;
            issue_tgt = pend_pc_q;
          end
        end
      end
      default: st_d = BOOT;
    endcase

    if (issue) begin
      jump_cs  = 1'b1;
      next_pc  = issue_tgt;
      cnt_d    = cnt_q + 16'd1;
      flush_if = 1'b1;
      flush_id = (issue_src != SRC_JUMP);
      flush_ex = (issue_src == SRC_TRAP);
    end

    // Reset forces the hold values straight through, without a clock edge.
    if (!rst_n) begin
      stall    = 1'b1;
      jump_cs  = 1'b0;
      next_pc  = RESET_VEC;
      flush_if = 1'b1;
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= BOOT;
      pend_pc_q  <= 32'h0;
      pend_src_q <= SRC_JUMP;
      cnt_q      <= 16'h0;
    end else begin
      st_q       <= st_d;
      pend_pc_q  <= pend_pc_d;
      pend_src_q <= pend_src_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
